// File: rtl/mul_share_pkg.sv
`default_nettype none
// ============================================================================
// mul_share_pkg : shared types and width helpers for mul_share_arbiter
// Rev 1.0
// ============================================================================
package mul_share_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam int DEF_WIDTH_LOG = 5;
   localparam int DEF_N_REQ     = 4;

   function automatic int width_of(input int wl);
      return 1 << wl;
   endfunction

   function automatic int out_width_of(input int wl);
      return 2 * (1 << wl);
   endfunction

endpackage
`default_nettype wire

// File: rtl/mul_iter_core.sv
`default_nettype none
// ============================================================================
// mul_iter_core : iterative shift-and-add multiplier with early termination
// Rev 1.0
// ============================================================================
module mul_iter_core
   import mul_share_pkg::*;
#(
   parameter int WIDTH_LOG = DEF_WIDTH_LOG,
   localparam int WIDTH     = width_of(WIDTH_LOG),
   localparam int OUT_WIDTH = out_width_of(WIDTH_LOG)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start_i,
   input  logic [WIDTH-1:0]     a_i,
   input  logic [WIDTH-1:0]     b_i,
   output logic                 done_o,
   output logic [OUT_WIDTH-1:0] product_o
);

   logic [WIDTH-1:0]     a_q,   a_d;
   logic [WIDTH-1:0]     b_q,   b_d;
   logic [OUT_WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH_LOG:0]   cnt_q, cnt_d;
   logic                 run_q, run_d;
   logic [OUT_WIDTH-1:0] a_ext;

   assign a_ext     = {{WIDTH{1'b0}}, a_q};
   assign product_o = acc_q;

   always_comb begin
      a_d    = a_q;
      b_d    = b_q;
      acc_d  = acc_q;
      cnt_d  = cnt_q;
      run_d  = run_q;
      done_o = 1'b0;
      if (start_i) begin
         a_d   = a_i;
         b_d   = b_i;
         acc_d = '0;
         cnt_d = '0;
         run_d = 1'b1;
      end else if (run_q) begin
         // Stop as soon as no multiplier bits remain; cnt is bounded by WIDTH.
         if ((a_q == '0) || (b_q == '0)) begin
            done_o = 1'b1;
            run_d  = 1'b0;
         end else begin
            if (b_q[0]) begin
               acc_d = acc_q + (a_ext << cnt_q);
            end
            b_d   = b_q >> 1;
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_q   <= '0;
         b_q   <= '0;
         acc_q <= '0;
         cnt_q <= '0;
         run_q <= 1'b0;
      end else begin
         a_q   <= a_d;
         b_q   <= b_d;
         acc_q <= acc_d;
         cnt_q <= cnt_d;
         run_q <= run_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/mul_share_arbiter.sv
`default_nettype none
// ============================================================================
// mul_share_arbiter : round-robin sharing of one iterative multiplier
// Rev 1.0
// ============================================================================
module mul_share_arbiter
   import mul_share_pkg::*;
#(
   parameter int WIDTH_LOG = DEF_WIDTH_LOG,
   parameter int N_REQ     = DEF_N_REQ,
   localparam int WIDTH     = width_of(WIDTH_LOG),
   localparam int OUT_WIDTH = out_width_of(WIDTH_LOG),
   localparam int ID_W      = $clog2(N_REQ)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_REQ-1:0]       req_valid,
   input  logic [N_REQ*WIDTH-1:0] req_a,
   input  logic [N_REQ*WIDTH-1:0] req_b,
   output logic [N_REQ-1:0]       req_ready,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [OUT_WIDTH-1:0]   rsp_o,
   output logic [ID_W-1:0]        rsp_id,
   output logic                   busy
);

   state_e               state_q, state_d;
   logic [ID_W-1:0]      ptr_q, ptr_d;
   logic [ID_W-1:0]      id_q, id_d;
   logic [ID_W-1:0]      rsp_id_q, rsp_id_d;
   logic [OUT_WIDTH-1:0] rsp_q, rsp_d;

   logic [WIDTH-1:0]     a_arr [N_REQ];
   logic [WIDTH-1:0]     b_arr [N_REQ];
   logic                 found;
   logic [ID_W-1:0]      sel_id;
   logic [ID_W-1:0]      cand;
   logic                 grant;
   logic                 core_start;
   logic                 core_done;
   logic [OUT_WIDTH-1:0] core_product;

   function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int off);
      int s;
      s = int'(base) + off;
      if (s >= N_REQ) begin
         s = s - N_REQ;
      end
      return ID_W'(s);
   endfunction

   for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
      assign a_arr[g] = req_a[g*WIDTH +: WIDTH];
      assign b_arr[g] = req_b[g*WIDTH +: WIDTH];
   end

   // First valid requester at or after ptr, wrapping around.
   always_comb begin
      found  = 1'b0;
      sel_id = '0;
      cand   = '0;
      for (int k = 0; k < N_REQ; k++) begin
         cand = wrap_add(ptr_q, k);
         if (!found && req_valid[cand]) begin
            found  = 1'b1;
            sel_id = cand;
         end
      end
   end

   assign grant = (state_q == ST_IDLE) && !rst && found;

   always_comb begin
      req_ready = '0;
      if (grant) begin
         req_ready[sel_id] = 1'b1;
      end
   end

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      id_d       = id_q;
      rsp_d      = rsp_q;
      rsp_id_d   = rsp_id_q;
      core_start = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (grant) begin
               core_start = 1'b1;
               id_d       = sel_id;
               ptr_d      = wrap_add(sel_id, 1);
               state_d    = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (core_done) begin
               rsp_d    = core_product;
               rsp_id_d = id_q;
               state_d  = ST_DONE;
            end
         end
         ST_DONE: begin
            if (rsp_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         ptr_q    <= '0;
         id_q     <= '0;
         rsp_q    <= '0;
         rsp_id_q <= '0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         id_q     <= id_d;
         rsp_q    <= rsp_d;
         rsp_id_q <= rsp_id_d;
      end
   end

   mul_iter_core #(
      .WIDTH_LOG (WIDTH_LOG)
   ) u_core (
      .clk       (clk),
      .rst       (rst),
      .start_i   (core_start),
      .a_i       (a_arr[sel_id]),
      .b_i       (b_arr[sel_id]),
      .done_o    (core_done),
      .product_o (core_product)
   );

   assign rsp_valid = (state_q == ST_DONE);
   assign rsp_o     = rsp_q;
   assign rsp_id    = rsp_id_q;
   assign busy      = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mul_share_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mul_share_arbiter : directed vectors, corner sequences and random model
// Rev 1.0
// ============================================================================
module tb_mul_share_arbiter;

   localparam int WL  = 5;
   localparam int W   = 32;
   localparam int OW  = 64;
   localparam int N   = 4;
   localparam int IDW = 2;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   req_valid;
   logic [N*W-1:0] req_a;
   logic [N*W-1:0] req_b;
   logic [N-1:0]   req_ready;
   logic           rsp_valid;
   logic           rsp_ready;
   logic [OW-1:0]  rsp_o;
   logic [IDW-1:0] rsp_id;
   logic           busy;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      int          idx;
      logic [W-1:0]  a;
      logic [W-1:0]  b;
      logic [OW-1:0] p;
      int          lat;
   } vec_t;

   vec_t vecs [6];

   always #5 clk = ~clk;

   mul_share_arbiter #(.WIDTH_LOG(WL), .N_REQ(N)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_o     (rsp_o),
      .rsp_id    (rsp_id),
      .busy      (busy)
   );

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
      req_a[i*W +: W] = a;
      req_b[i*W +: W] = b;
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      req_valid = '0;
      rsp_ready = 1'b0;
      next_cycle();
      rst = 1'b0;
   endtask

   function automatic int bitlen(input logic [W-1:0] v);
      int l;
      l = 0;
      for (int k = 0; k < W; k++) if (v[k]) l = k + 1;
      return l;
   endfunction

   function automatic int onehot_idx(input logic [N-1:0] v);
      int r;
      r = -1;
      for (int k = 0; k < N; k++) if (v[k]) r = k;
      return r;
   endfunction

   // Called one cycle after the handshake; c counts cycles since the handshake.
   task automatic wait_rsp(input string nm, output int c);
      bit seen;
      seen = 1'b0;
      c    = 1;
      while (!seen && c <= 60) begin
         settle();
         if (rsp_valid === 1'b1) seen = 1'b1;
         else begin
            next_cycle();
            c++;
         end
      end
      check({nm, " rsp seen"}, 64'(seen), 64'd1);
   endtask

   task automatic run_single(input string nm, input int idx, input logic [W-1:0] a,
                             input logic [W-1:0] b, input logic [OW-1:0] exp_p, input int exp_lat);
      int c;
      req_valid      = '0;
      req_valid[idx] = 1'b1;
      set_req(idx, a, b);
      rsp_ready = 1'b1;
      settle();
      check({nm, " grant"}, 64'(req_ready), 64'(1 << idx));
      next_cycle();
      req_valid = '0;
      set_req(idx, $urandom, $urandom);
      wait_rsp(nm, c);
      check({nm, " latency"}, 64'(c), 64'(exp_lat));
      check({nm, " product"}, rsp_o, exp_p);
      check({nm, " id"}, 64'(rsp_id), 64'(idx));
      check({nm, " busy"}, 64'(busy), 64'd1);
      next_cycle();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int c;
      int ng;
      int nr;
      int hits;
      int m_state;
      int m_ptr;
      int m_left;
      int m_id;
      logic [OW-1:0] m_prod;
      logic [N-1:0]  exp_ready;

      vecs[0] = '{idx: 2, a: 32'd3,          b: 32'd5,          p: 64'd15,                  lat: 5};
      vecs[1] = '{idx: 0, a: 32'd0,          b: 32'hFFFF_FFFF,  p: 64'd0,                   lat: 2};
      vecs[2] = '{idx: 0, a: 32'd7,          b: 32'd0,          p: 64'd0,                   lat: 2};
      vecs[3] = '{idx: 1, a: 32'hFFFF_FFFF,  b: 32'hFFFF_FFFF,  p: 64'hFFFF_FFFE_0000_0001, lat: 34};
      vecs[4] = '{idx: 3, a: 32'd1,          b: 32'h8000_0000,  p: 64'h0000_0000_8000_0000, lat: 34};
      vecs[5] = '{idx: 1, a: 32'h0000_FFFF,  b: 32'd1,          p: 64'h0000_0000_0000_FFFF, lat: 3};

      // Reset behaviour, with all requesters asserting valid.
      rst       = 1'b1;
      req_valid = '1;
      req_a     = '0;
      req_b     = '0;
      rsp_ready = 1'b0;
      next_cycle();
      next_cycle();
      settle();
      check("reset req_ready", 64'(req_ready), 64'd0);
      check("reset rsp_valid", 64'(rsp_valid), 64'd0);
      check("reset rsp_o", rsp_o, 64'd0);
      check("reset rsp_id", 64'(rsp_id), 64'd0);
      check("reset busy", 64'(busy), 64'd0);
      next_cycle();
      rst       = 1'b0;
      req_valid = '0;

      for (int i = 0; i < 6; i++) begin
         run_single($sformatf("vec%0d", i), vecs[i].idx, vecs[i].a, vecs[i].b, vecs[i].p, vecs[i].lat);
      end

      // Fairness: all requesters continuously valid from reset.
      do_reset();
      for (int i = 0; i < N; i++) set_req(i, W'(i + 1), 32'd2);
      req_valid = '1;
      rsp_ready = 1'b1;
      ng = 0;
      nr = 0;
      for (int cy = 0; cy < 200 && nr < 8; cy++) begin
         settle();
         check("fair onehot", 64'($countones(req_ready) <= 1), 64'd1);
         if (req_ready != '0) begin
            check("fair grant", 64'(onehot_idx(req_ready)), 64'(ng % N));
            ng++;
         end
         if (rsp_valid) begin
            check("fair rsp_id", 64'(rsp_id), 64'(nr % N));
            check("fair rsp_o", rsp_o, 64'(2 * (nr % N + 1)));
            nr++;
         end
         next_cycle();
      end
      req_valid = '0;
      check("fair responses", 64'(nr), 64'd8);

      // Back-pressure in DONE.
      do_reset();
      req_valid = 4'b0010;
      set_req(1, 32'd6, 32'd7);
      rsp_ready = 1'b0;
      next_cycle();
      req_valid = '0;
      wait_rsp("bp", c);
      for (int k = 0; k < 10; k++) begin
         req_valid = '1;
         req_a     = {$urandom, $urandom, $urandom, $urandom};
         req_b     = {$urandom, $urandom, $urandom, $urandom};
         settle();
         check("bp rsp_valid", 64'(rsp_valid), 64'd1);
         check("bp rsp_o", rsp_o, 64'd42);
         check("bp rsp_id", 64'(rsp_id), 64'd1);
         check("bp req_ready", 64'(req_ready), 64'd0);
         next_cycle();
      end
      for (int i = 0; i < N; i++) set_req(i, W'(i + 10), 32'd1);
      rsp_ready = 1'b1;
      settle();
      check("bp release valid", 64'(rsp_valid), 64'd1);
      check("bp no grant on rsp", 64'(req_ready), 64'd0);
      next_cycle();
      settle();
      check("bp idle busy", 64'(busy), 64'd0);
      check("bp idle rsp_valid", 64'(rsp_valid), 64'd0);
      check("bp next grant", 64'(req_ready), 64'b0100);
      next_cycle();
      req_valid = '0;
      wait_rsp("bp2", c);
      check("bp2 rsp_o", rsp_o, 64'd12);
      check("bp2 rsp_id", 64'(rsp_id), 64'd2);
      next_cycle();

      // Reset while an operation is in flight.
      do_reset();
      req_valid = 4'b0001;
      set_req(0, 32'd9, 32'hFF);
      rsp_ready = 1'b1;
      next_cycle();
      req_valid = '0;
      next_cycle();
      next_cycle();
      settle();
      check("abort busy before", 64'(busy), 64'd1);
      rst       = 1'b1;
      req_valid = '1;
      #1;
      check("abort req_ready in rst", 64'(req_ready), 64'd0);
      next_cycle();
      rst       = 1'b0;
      req_valid = '0;
      settle();
      check("abort busy", 64'(busy), 64'd0);
      check("abort rsp_valid", 64'(rsp_valid), 64'd0);
      check("abort rsp_o", rsp_o, 64'd0);
      check("abort rsp_id", 64'(rsp_id), 64'd0);
      hits = 0;
      for (int k = 0; k < 15; k++) begin
         next_cycle();
         settle();
         if (rsp_valid !== 1'b0) hits++;
      end
      check("abort no stale rsp", 64'(hits), 64'd0);
      next_cycle();
      req_valid = 4'b1001;
      set_req(0, 32'd11, 32'd13);
      set_req(3, 32'd11, 32'd13);
      settle();
      check("abort ptr zero", 64'(req_ready), 64'b0001);
      next_cycle();
      req_valid = '0;
      wait_rsp("abort r0", c);
      check("abort r0 rsp_o", rsp_o, 64'd143);
      next_cycle();
      run_single("abort r3", 3, 32'd11, 32'd13, 64'd143, 6);

      // Random traffic against a behavioural model.
      do_reset();
      m_state = 0;
      m_ptr   = 0;
      m_left  = 0;
      m_id    = 0;
      m_prod  = '0;
      for (int cy = 0; cy < 4000; cy++) begin
         req_valid = N'($urandom_range(0, 15));
         for (int i = 0; i < N; i++) begin
            set_req(i, ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom),
                       ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom) >> $urandom_range(0, 31));
         end
         rsp_ready = ($urandom_range(0, 3) != 0);
         settle();
         exp_ready = '0;
         if (m_state == 0) begin
            for (int k = 0; k < N; k++) begin
               if (exp_ready == '0 && req_valid[(m_ptr + k) % N]) exp_ready[(m_ptr + k) % N] = 1'b1;
            end
         end
         check("rnd req_ready", 64'(req_ready), 64'(exp_ready));
         check("rnd rsp_valid", 64'(rsp_valid), 64'(m_state == 2));
         check("rnd busy", 64'(busy), 64'(m_state != 0));
         if (m_state == 2) begin
            check("rnd rsp_o", rsp_o, m_prod);
            check("rnd rsp_id", 64'(rsp_id), 64'(m_id));
         end
         if (m_state == 0) begin
            if (exp_ready != '0) begin
               m_id    = onehot_idx(exp_ready);
               m_prod  = 64'(req_a[m_id*W +: W]) * 64'(req_b[m_id*W +: W]);
               m_left  = ((req_a[m_id*W +: W] == '0) || (req_b[m_id*W +: W] == '0))
                         ? 1 : bitlen(req_b[m_id*W +: W]) + 1;
               m_ptr   = (m_id + 1) % N;
               m_state = 1;
            end
         end else if (m_state == 1) begin
            m_left--;
            if (m_left == 0) m_state = 2;
         end else if (rsp_ready) begin
            m_state = 0;
         end
         next_cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
